// File: rtl/oam_dma_arbiter.sv
// Shares the CPU memory bus between the 6502 core and the 2A03 sprite DMA engine.
// A CPU write to DMA_REG_ADDR halts the core and copies one 256-byte page to OAM.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] latch;
  logic       parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= 8'h00;
      page   <= 8'h00;
      latch  <= 8'h00;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        S_IDLE: begin
          if (cpu_addr == DMA_REG_ADDR && !cpu_rw) begin
            page  <= cpu_wdata;
            idx   <= 8'h00;
            state <= S_HALT;
          end
        end
        // Reads must land on parity=0 cycles; an odd HALT goes straight to READ.
        S_HALT:  state <= parity ? S_READ : S_ALIGN;
        S_ALIGN: state <= S_READ;
        S_READ: begin
          latch <= mem_rdata;
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (idx == 8'hFF) begin
            idx   <= 8'h00;
            state <= S_IDLE;
          end else begin
            idx   <= idx + 8'h01;
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_rw    = cpu_rw;
    case (state)
      S_HALT, S_ALIGN: bus_rw = 1'b1;
      S_READ: begin
        bus_addr = {page, idx};
        bus_rw   = 1'b1;
      end
      S_WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_wdata = latch;
        bus_rw    = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_rdy    = (state == S_IDLE);
  assign dma_active = (state != S_IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: alignment, data order, decode, mid-transfer
// reset and back-to-back transfers with page wrap.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  mem_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic        cpu_rdy;
  logic        dma_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rw     (cpu_rw),
    .mem_rdata  (mem_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rw     (bus_rw),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Memory image: byte at {hi,lo} is lo^hi^59, so page 03 holds i^5A.
  assign mem_rdata = bus_addr[7:0] ^ bus_addr[15:8] ^ 8'h59;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_rw    = rw;
    #1;
  endtask

  task automatic chk_mirror(input string tag, input logic [15:0] a, input logic [7:0] d,
                            input logic rw);
    chk({tag, "_rdy"},    32'(cpu_rdy),    32'd1);
    chk({tag, "_active"}, 32'(dma_active), 32'd0);
    chk({tag, "_addr"},   32'(bus_addr),   32'(a));
    chk({tag, "_wdata"},  32'(bus_wdata),  32'(d));
    chk({tag, "_rw"},     32'(bus_rw),     32'(rw));
  endtask

  // Entered at the HALT cycle; leaves in the first IDLE cycle, or inside write
  // number stop_after when stop_after < 256.
  task automatic run_dma(input logic [7:0] page, input logic align, input int stop_after);
    logic [7:0] i8;
    chk("halt_rdy",    32'(cpu_rdy),    32'd0);
    chk("halt_active", 32'(dma_active), 32'd1);
    chk("halt_addr",   32'(bus_addr),   32'h4014);
    chk("halt_rw",     32'(bus_rw),     32'd1);
    tick;
    if (align) begin
      chk("align_rdy",  32'(cpu_rdy),  32'd0);
      chk("align_addr", 32'(bus_addr), 32'h4014);
      chk("align_rw",   32'(bus_rw),   32'd1);
      tick;
    end
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      chk("read_rdy",  32'(cpu_rdy),  32'd0);
      chk("read_addr", 32'(bus_addr), 32'({page, i8}));
      chk("read_rw",   32'(bus_rw),   32'd1);
      tick;
      chk("write_rdy",   32'(cpu_rdy),   32'd0);
      chk("write_addr",  32'(bus_addr),  32'h2004);
      chk("write_rw",    32'(bus_rw),    32'd0);
      chk("write_wdata", 32'(bus_wdata), 32'(i8 ^ page ^ 8'h59));
      if (i + 1 == stop_after && stop_after < 256) return;
      tick;
    end
    chk("done_rdy",    32'(cpu_rdy),    32'd1);
    chk("done_active", 32'(dma_active), 32'd0);
  endtask

  task automatic trigger(input logic [7:0] page, input int stop_after);
    int t;
    drive(16'h4014, page, 1'b0);
    chk_mirror("trig", 16'h4014, page, 1'b0);
    t = cyc;
    tick;
    run_dma(page, t[0], stop_after);
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = 16'h1234;
    cpu_wdata = 8'hA5;
    cpu_rw = 1'b0;
    #12;
    chk_mirror("reset", 16'h1234, 8'hA5, 1'b0);

    // Trigger in the first cycle after reset: HALT lands on parity 1, no ALIGN (513 cycles).
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    trigger(8'h02, 256);

    // Near-miss decodes pass straight through.
    drive(16'h4015, 8'h02, 1'b0);
    chk_mirror("dec_4015w", 16'h4015, 8'h02, 1'b0);
    tick;
    drive(16'h4014, 8'h77, 1'b1);
    chk_mirror("dec_4014r", 16'h4014, 8'h77, 1'b1);
    tick;
    drive(16'h4004, 8'h33, 1'b0);
    chk_mirror("dec_4004w", 16'h4004, 8'h33, 1'b0);
    tick;
    drive(16'h0000, 8'h00, 1'b1);
    chk_mirror("dec_after", 16'h0000, 8'h00, 1'b1);

    // Trigger on an odd cycle: ALIGN inserted (514 cycles); page 03 data is 5A,5B,...
    if (cyc[0] == 1'b0) tick;
    trigger(8'h03, 256);

    // Reset between edges after the 100th OAM write.
    trigger(8'h10, 100);
    @(posedge clk);
    #3;
    rst = 1'b1;
    cpu_addr = 16'h0123;
    cpu_wdata = 8'h00;
    cpu_rw = 1'b1;
    #1;
    chk("midrst_rdy",    32'(cpu_rdy),    32'd1);
    chk("midrst_active", 32'(dma_active), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      chk("post_rst_rdy",  32'(cpu_rdy),  32'd1);
      chk("post_rst_addr", 32'(bus_addr), 32'h0123);
      chk("post_rst_rw",   32'(bus_rw),   32'd1);
      tick;
    end

    // Page FF must end at FFFF with no carry; re-trigger on the very first IDLE cycle.
    trigger(8'hFF, 256);
    trigger(8'h00, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
